mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the data and address width of all ports.
REQ-002 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 ifu_req_valid in 1 / ifu_req_ready out 1 / ifu_req_addr in DATA_WIDTH: fetch read request.
REQ-005 ifu_resp_valid out 1 / ifu_resp_ready in 1 / ifu_resp_data out DATA_WIDTH: fetch response.
REQ-006 lsu_req_valid in 1 / lsu_req_ready out 1 / lsu_req_addr in DATA_WIDTH / lsu_req_wen in 1 / lsu_req_wdata in DATA_WIDTH / lsu_req_wmask in 4: load/store request.
REQ-007 lsu_resp_valid out 1 / lsu_resp_ready in 1 / lsu_resp_data out DATA_WIDTH: load/store response.
REQ-008 mem_req_valid out 1 / mem_req_ready in 1 / mem_req_addr out DATA_WIDTH / mem_req_wen out 1 / mem_req_wdata out DATA_WIDTH / mem_req_wmask out 4: shared memory request port.
REQ-009 mem_resp_valid in 1 / mem_resp_ready out 1 / mem_resp_data in DATA_WIDTH: shared memory response port.
REQ-010 busy out 1: high whenever state is not IDLE.

Function
REQ-011 The block SHALL be a 3-state FSM: IDLE, REQ, RESP; one outstanding transaction at most.
REQ-012 IDLE, single requester valid: that requester SHALL be granted.
REQ-013 IDLE, both valid: winner SHALL be the master not granted last (round-robin via 1-bit last_grant); last_grant resets to IFU so LSU wins first tie.
REQ-014 Grant: winner's req_ready SHALL be 1 combinationally in IDLE that cycle, loser's req_ready 0; req_ready of both SHALL be 0 outside IDLE.
REQ-015 On grant edge: addr/wen/wdata/wmask SHALL be latched (IFU grant: wen=0, wmask=0, wdata=0), owner and last_grant recorded, state -> REQ.
REQ-016 REQ: mem_req_valid=1 with latched fields held stable; on mem_req_valid&&mem_req_ready state -> RESP.
REQ-017 mem_req_valid and mem_req_* fields SHALL be 0 in IDLE and RESP.
REQ-018 RESP: mem_resp_ready SHALL equal owner's resp_ready; owner's resp_valid SHALL equal mem_resp_valid; owner's resp_data SHALL equal mem_resp_data (pass-through, no register).
REQ-019 Non-owner resp_valid SHALL be 0 and resp_data 0 in all states; mem_resp_ready SHALL be 0 outside RESP.
REQ-020 RESP: on mem_resp_valid&&mem_resp_ready state -> IDLE; stores SHALL also await one response beat.
REQ-021 mem_resp_valid outside RESP SHALL be ignored (no state change, not forwarded).
REQ-022 Minimum latency: grant at cycle T, mem_req_valid at T+1; with mem_req_ready at T+1 and mem_resp_valid+resp_ready at T+2, IDLE at T+3, next grant possible at T+3.
REQ-023 Requests deasserted before grant SHALL be dropped without effect; after grant the latched copy SHALL be used regardless of master inputs.
REQ-024 Backpressure of any length on mem_req_ready or resp_ready SHALL stall without losing or duplicating a beat.

Reset
REQ-025 rst=0 at a clock edge SHALL force state IDLE, last_grant=IFU, latched fields 0; all outputs then 0.
REQ-026 Reset mid-transaction (REQ or RESP) SHALL abandon the transaction; no response SHALL be delivered to either master afterward.

Verification
REQ-027 IFU-only read addr 0x80000000, mem returns 0x00000413 -> ifu_req_ready=1 at T, mem_req_addr=0x80000000 wen=0 at T+1, ifu_resp_data=0x00000413 at T+2, lsu_resp_valid=0 throughout.
REQ-028 Both valid from reset, IFU 0x80000004, LSU store 0x80001000 data 0xDEADBEEF mask 0xF -> LSU granted first with mem_req_wen=1, wdata=0xDEADBEEF; after its response IFU granted next.
REQ-029 Both continuously valid for 6 transactions -> grants alternate LSU, IFU, LSU, IFU, LSU, IFU.
REQ-030 mem_req_ready held 0 for 5 cycles in REQ -> mem_req_valid and fields stable 5 cycles; ready=1 -> RESP next cycle; lsu_req_addr changed during stall not reflected.
REQ-031 lsu_resp_ready=0 for 3 cycles with mem_resp_valid=1 -> mem_resp_ready=0, state stays RESP; ready=1 -> one beat delivered, IDLE next cycle.
REQ-032 rst=0 asserted in RESP -> next cycle busy=0, all outputs 0; a later mem_resp_valid pulse produces no resp_valid on either master.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Arbitrates a fetch unit (IFU) and a load/store unit (LSU) onto one shared
// memory port, with at most one transaction outstanding.
//
// Handshake rule for every channel: a beat transfers on a rising clk edge
// where valid && ready are both 1. A master holding valid may change its
// payload only after the beat transfers. Ready may depend combinationally on
// valid.
//
// Ports
//   clk, rst                  clock, synchronous active-low reset
//   ifu_req_*  / ifu_resp_*   fetch request (read only) and response
//   lsu_req_*  / lsu_resp_*   load/store request and response
//   mem_req_*  / mem_resp_*   shared memory request and response
//   busy                      high whenever the FSM is not IDLE
//   dbg_state                 current FSM state (0 IDLE, 1 REQ, 2 RESP)
module mem_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [DATA_WIDTH-1:0] ifu_req_addr,
  output logic                  ifu_resp_valid,
  input  logic                  ifu_resp_ready,
  output logic [DATA_WIDTH-1:0] ifu_resp_data,
  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic [DATA_WIDTH-1:0] lsu_req_addr,
  input  logic                  lsu_req_wen,
  input  logic [DATA_WIDTH-1:0] lsu_req_wdata,
  input  logic [3:0]            lsu_req_wmask,
  output logic                  lsu_resp_valid,
  input  logic                  lsu_resp_ready,
  output logic [DATA_WIDTH-1:0] lsu_resp_data,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [DATA_WIDTH-1:0] mem_req_addr,
  output logic                  mem_req_wen,
  output logic [DATA_WIDTH-1:0] mem_req_wdata,
  output logic [3:0]            mem_req_wmask,
  input  logic                  mem_resp_valid,
  output logic                  mem_resp_ready,
  input  logic [DATA_WIDTH-1:0] mem_resp_data,
  output logic                  busy,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Master identifiers for owner / last_grant.
  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  state_t                state_q, state_d;
  logic                  owner_q;
  logic                  last_grant_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic                  wen_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [3:0]            wmask_q;

  logic grant_ifu, grant_lsu;

  // Round-robin tie break: on a tie the master that was not granted last
  // wins. A lone requester always wins.
  always_comb begin
    grant_lsu = 1'b0;
    grant_ifu = 1'b0;
    if (state_q == ST_IDLE) begin
      grant_lsu = lsu_req_valid && (!ifu_req_valid || (last_grant_q == OWN_IFU));
      grant_ifu = ifu_req_valid && !grant_lsu;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (grant_ifu || grant_lsu) state_d = ST_REQ;
      ST_REQ:  if (mem_req_ready)          state_d = ST_RESP;
      ST_RESP: if (mem_resp_valid && mem_resp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Request capture: once granted, the latched copy drives the memory port,
  // so later changes on the master inputs have no effect.
  always_ff @(posedge clk) begin
    if (!rst) begin
      owner_q      <= OWN_IFU;
      last_grant_q <= OWN_IFU;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
      wmask_q      <= 4'h0;
    end else if (grant_lsu) begin
      owner_q      <= OWN_LSU;
      last_grant_q <= OWN_LSU;
      addr_q       <= lsu_req_addr;
      wen_q        <= lsu_req_wen;
      wdata_q      <= lsu_req_wdata;
      wmask_q      <= lsu_req_wmask;
    end else if (grant_ifu) begin
      owner_q      <= OWN_IFU;
      last_grant_q <= OWN_IFU;
      addr_q       <= ifu_req_addr;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
      wmask_q      <= 4'h0;
    end
  end

  // Outputs. Request-side fields are zeroed outside REQ because the latched
  // copy survives after the transaction completes. Requester readies are
  // held low while reset is asserted so no grant is ever signalled then.
  always_comb begin
    ifu_req_ready  = rst && grant_ifu;
    lsu_req_ready  = rst && grant_lsu;

    mem_req_valid  = 1'b0;
    mem_req_addr   = '0;
    mem_req_wen    = 1'b0;
    mem_req_wdata  = '0;
    mem_req_wmask  = 4'h0;
    if (state_q == ST_REQ) begin
      mem_req_valid = 1'b1;
      mem_req_addr  = addr_q;
      mem_req_wen   = wen_q;
      mem_req_wdata = wdata_q;
      mem_req_wmask = wmask_q;
    end

    // Response path is a pure pass-through to the owner only, and only in
    // RESP; stray response beats in other states are not forwarded.
    mem_resp_ready = 1'b0;
    ifu_resp_valid = 1'b0;
    ifu_resp_data  = '0;
    lsu_resp_valid = 1'b0;
    lsu_resp_data  = '0;
    if (state_q == ST_RESP) begin
      if (owner_q == OWN_LSU) begin
        mem_resp_ready = lsu_resp_ready;
        lsu_resp_valid = mem_resp_valid;
        lsu_resp_data  = mem_resp_data;
      end else begin
        mem_resp_ready = ifu_resp_ready;
        ifu_resp_valid = mem_resp_valid;
        ifu_resp_data  = mem_resp_data;
      end
    end

    busy      = (state_q != ST_IDLE);
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed self-checking bench for mem_arbiter. Inputs change 1 ns after
// each rising edge; outputs are compared 1 ns after that, well away from
// the active edge.
module tb_mem_arbiter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         ifu_req_valid, ifu_req_ready;
  logic [W-1:0] ifu_req_addr;
  logic         ifu_resp_valid, ifu_resp_ready;
  logic [W-1:0] ifu_resp_data;
  logic         lsu_req_valid, lsu_req_ready;
  logic [W-1:0] lsu_req_addr;
  logic         lsu_req_wen;
  logic [W-1:0] lsu_req_wdata;
  logic [3:0]   lsu_req_wmask;
  logic         lsu_resp_valid, lsu_resp_ready;
  logic [W-1:0] lsu_resp_data;
  logic         mem_req_valid, mem_req_ready;
  logic [W-1:0] mem_req_addr;
  logic         mem_req_wen;
  logic [W-1:0] mem_req_wdata;
  logic [3:0]   mem_req_wmask;
  logic         mem_resp_valid, mem_resp_ready;
  logic [W-1:0] mem_resp_data;
  logic         busy;
  logic [1:0]   dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  mem_arbiter #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_req_addr(ifu_req_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
    .ifu_resp_data(ifu_resp_data),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_req_addr(lsu_req_addr), .lsu_req_wen(lsu_req_wen),
    .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
    .lsu_resp_data(lsu_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
    .mem_resp_data(mem_resp_data),
    .busy(busy), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Checker
  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    ifu_req_valid  = 1'b0; ifu_req_addr  = '0; ifu_resp_ready = 1'b0;
    lsu_req_valid  = 1'b0; lsu_req_addr  = '0; lsu_req_wen    = 1'b0;
    lsu_req_wdata  = '0;   lsu_req_wmask = 4'h0; lsu_resp_ready = 1'b0;
    mem_req_ready  = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Every output is zero (requester inputs idle).
  task automatic check_quiet(input string tag);
    check({tag, ".busy"},      W'(busy), 0);
    check({tag, ".state"},     W'(dbg_state), 0);
    check({tag, ".ifu_rdy"},   W'(ifu_req_ready), 0);
    check({tag, ".lsu_rdy"},   W'(lsu_req_ready), 0);
    check({tag, ".mreq_v"},    W'(mem_req_valid), 0);
    check({tag, ".mreq_addr"}, mem_req_addr, 0);
    check({tag, ".mreq_wd"},   mem_req_wdata, 0);
    check({tag, ".mresp_rdy"}, W'(mem_resp_ready), 0);
    check({tag, ".ifu_rv"},    W'(ifu_resp_valid), 0);
    check({tag, ".lsu_rv"},    W'(lsu_resp_valid), 0);
    check({tag, ".ifu_rd"},    ifu_resp_data, 0);
    check({tag, ".lsu_rd"},    lsu_resp_data, 0);
  endtask

  initial begin
    logic exp_lsu;
    logic [W-1:0] rdata;
    logic [W-1:0] exp_q[$];

    rst = 1'b0;
    clear_inputs();

    // Reset state
    tick();
    tick();
    settle();
    check_quiet("reset");
    rst = 1'b1;

    // IFU-only read
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0000;
    settle();
    check("rd.ifu_rdy_T", W'(ifu_req_ready), 1);
    check("rd.lsu_rdy_T", W'(lsu_req_ready), 0);
    tick();
    ifu_req_valid = 1'b0; ifu_req_addr = 32'h1234_5678;  // must not leak
    mem_req_ready = 1'b1;
    settle();
    check("rd.mreq_v_T1",    W'(mem_req_valid), 1);
    check("rd.mreq_addr_T1", mem_req_addr, 32'h8000_0000);
    check("rd.mreq_wen_T1",  W'(mem_req_wen), 0);
    check("rd.busy_T1",      W'(busy), 1);
    check("rd.ifu_rdy_T1",   W'(ifu_req_ready), 0);
    check("rd.lsu_rv_T1",    W'(lsu_resp_valid), 0);
    tick();
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_0413; ifu_resp_ready = 1'b1;
    settle();
    check("rd.ifu_rv_T2",    W'(ifu_resp_valid), 1);
    check("rd.ifu_rd_T2",    ifu_resp_data, 32'h0000_0413);
    check("rd.mresp_rdy_T2", W'(mem_resp_ready), 1);
    check("rd.mreq_v_T2",    W'(mem_req_valid), 0);
    check("rd.lsu_rv_T2",    W'(lsu_resp_valid), 0);
    check("rd.lsu_rd_T2",    lsu_resp_data, 0);
    tick();
    mem_resp_valid = 1'b0; ifu_resp_ready = 1'b0;
    settle();
    check("rd.state_T3",  W'(dbg_state), 0);
    check("rd.ifu_rv_T3", W'(ifu_resp_valid), 0);

    // Stray response beat in IDLE is ignored
    mem_resp_valid = 1'b1; mem_resp_data = 32'h5555_AAAA; ifu_resp_ready = 1'b1;
    settle();
    check("stray.ifu_rv",    W'(ifu_resp_valid), 0);
    check("stray.mresp_rdy", W'(mem_resp_ready), 0);
    tick();
    settle();
    check("stray.state", W'(dbg_state), 0);
    clear_inputs();

    // Both continuously valid: tie alternates LSU, IFU, ...
    do_reset();
    ifu_req_valid = 1'b1; ifu_req_addr  = 32'h8000_0004;
    lsu_req_valid = 1'b1; lsu_req_addr  = 32'h8000_1000;
    lsu_req_wen   = 1'b1; lsu_req_wdata = 32'hDEAD_BEEF; lsu_req_wmask = 4'hF;
    mem_req_ready = 1'b1; ifu_resp_ready = 1'b1; lsu_resp_ready = 1'b1;
    for (int i = 0; i < 6; i++) exp_q.push_back(32'h0000_1000 + W'(i));
    for (int i = 0; i < 6; i++) begin
      exp_lsu = (i % 2 == 0);
      mem_resp_valid = 1'b0;
      settle();
      check($sformatf("rr%0d.lsu_rdy", i), W'(lsu_req_ready), W'(exp_lsu));
      check($sformatf("rr%0d.ifu_rdy", i), W'(ifu_req_ready), W'(!exp_lsu));
      tick();
      settle();
      check($sformatf("rr%0d.mreq_v", i),    W'(mem_req_valid), 1);
      check($sformatf("rr%0d.mreq_addr", i), mem_req_addr,
            exp_lsu ? 32'h8000_1000 : 32'h8000_0004);
      check($sformatf("rr%0d.mreq_wen", i),  W'(mem_req_wen), W'(exp_lsu));
      check($sformatf("rr%0d.mreq_wd", i),   mem_req_wdata,
            exp_lsu ? 32'hDEAD_BEEF : 32'h0);
      check($sformatf("rr%0d.mreq_wm", i),   W'(mem_req_wmask),
            exp_lsu ? 32'hF : 32'h0);
      tick();
      rdata = exp_q.pop_front();
      mem_resp_valid = 1'b1; mem_resp_data = rdata;
      settle();
      check($sformatf("rr%0d.lsu_rv", i), W'(lsu_resp_valid), W'(exp_lsu));
      check($sformatf("rr%0d.ifu_rv", i), W'(ifu_resp_valid), W'(!exp_lsu));
      check($sformatf("rr%0d.rdata", i), exp_lsu ? lsu_resp_data : ifu_resp_data, rdata);
      check($sformatf("rr%0d.other_rd", i), exp_lsu ? ifu_resp_data : lsu_resp_data, 0);
      if (i == 5) begin
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;  // drop both before next grant
      end
      tick();
    end
    mem_resp_valid = 1'b0;
    settle();
    check("rr.end_busy", W'(busy), 0);
    tick();
    settle();
    check("rr.dropped_busy", W'(busy), 0);
    clear_inputs();

    // Request backpressure: 5 stall cycles, LSU inputs change meanwhile
    do_reset();
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h0000_0100;
    lsu_req_wen = 1'b1; lsu_req_wdata = 32'h0BAD_F00D; lsu_req_wmask = 4'h3;
    settle();
    check("bp.lsu_rdy", W'(lsu_req_ready), 1);
    tick();
    lsu_req_addr = 32'h0000_0999; lsu_req_wdata = 32'h1111_1111; lsu_req_wmask = 4'hC;
    for (int k = 0; k < 5; k++) begin
      mem_req_ready = 1'b0;
      settle();
      check($sformatf("bp%0d.mreq_v", k),    W'(mem_req_valid), 1);
      check($sformatf("bp%0d.mreq_addr", k), mem_req_addr, 32'h0000_0100);
      check($sformatf("bp%0d.mreq_wd", k),   mem_req_wdata, 32'h0BAD_F00D);
      check($sformatf("bp%0d.mreq_wm", k),   W'(mem_req_wmask), 32'h3);
      check($sformatf("bp%0d.lsu_rdy", k),   W'(lsu_req_ready), 0);
      tick();
    end
    mem_req_ready = 1'b1;
    lsu_req_valid = 1'b0;
    settle();
    check("bp.state_req", W'(dbg_state), 1);
    tick();
    mem_req_ready = 1'b0;
    settle();
    check("bp.state_resp", W'(dbg_state), 2);
    check("bp.mreq_v_resp", W'(mem_req_valid), 0);

    // Response backpressure: lsu_resp_ready low 3 cycles
    mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_CAFE;
    for (int k = 0; k < 3; k++) begin
      lsu_resp_ready = 1'b0;
      settle();
      check($sformatf("rbp%0d.mresp_rdy", k), W'(mem_resp_ready), 0);
      check($sformatf("rbp%0d.state", k),     W'(dbg_state), 2);
      tick();
    end
    lsu_resp_ready = 1'b1;
    settle();
    check("rbp.mresp_rdy", W'(mem_resp_ready), 1);
    check("rbp.lsu_rv",    W'(lsu_resp_valid), 1);
    check("rbp.lsu_rd",    lsu_resp_data, 32'h0000_CAFE);
    tick();
    settle();
    check("rbp.state_idle", W'(dbg_state), 0);
    check("rbp.lsu_rv_idle", W'(lsu_resp_valid), 0);
    clear_inputs();

    // Reset in RESP abandons the transaction
    do_reset();
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h0000_0040;
    tick();
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    settle();
    check("rr_rst.state_resp", W'(dbg_state), 2);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    settle();
    check_quiet("rst_resp");
    mem_resp_valid = 1'b1; mem_resp_data = 32'hFFFF_0000;
    ifu_resp_ready = 1'b1; lsu_resp_ready = 1'b1;
    settle();
    check("rst_resp.ifu_rv_pulse", W'(ifu_resp_valid), 0);
    check("rst_resp.lsu_rv_pulse", W'(lsu_resp_valid), 0);
    tick();
    mem_resp_valid = 1'b0;
    settle();
    check("rst_resp.state_after", W'(dbg_state), 0);

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time limit: the directed sequence needs far fewer cycles.
  initial begin
    #100000;
    n_err++;
    $display("FAIL timeout: sequence did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "timeout");
  end

endmodule
